multi_bank_cascade_loader: RTL and testbench
============================================

// Module: multi_bank_cascade_loader
// PURPOSE
//  Parametrised successor of the single-array cascade loader. Accepts a stream of IN_WIDTH beats,
//  unpacks each beat into WORD_SIZE words (LSB first) and writes them into one of NUM_BANKS
//  cascade-cache banks, starting at address 0. Loads are host-commanded (bank, word count).
//  Sits between the input port adapter and the per-bank cascade cache RAMs.
// PARAMETERS
//  IN_WIDTH    64  input beat width; must be an integer multiple of WORD_SIZE
//  WORD_SIZE   32  cache word width written per cycle
//  ADDR_WIDTH  10  bank address width; bank depth = 2**ADDR_WIDTH
//  NUM_BANKS   4   number of destination banks (>=1)
// PORTS
//  clk          in   1                        single clock, all logic rising-edge
//  reset        in   1                        synchronous, active-high
//  start        in   1                        load command pulse; sampled only in IDLE
//  bank_sel     in   max(1,$clog2(NUM_BANKS)) destination bank, captured with start
//  word_count   in   ADDR_WIDTH+1             words to load (0..2**ADDR_WIDTH), captured with start
//  data         in   IN_WIDTH                 input beat
//  data_ready   in   1                        beat valid
//  data_wanted  out  1                        loader can accept a beat
//  we           out  NUM_BANKS                one-hot bank write enable
//  waddr        out  ADDR_WIDTH               shared write address
//  wdata        out  WORD_SIZE                shared write data
//  busy         out  1                        load in progress (state != IDLE)
//  loaded       out  1                        last load complete; held until next accepted start
//  chk_err      out  1                        only with CASCADE_LOADER_CHECKSUM_EN
// BEHAVIOUR
//  - Reset: state IDLE; data_wanted, we, busy, loaded, chk_err = 0; waddr, wdata = 0. Bank contents untouched.
//  - WPB = IN_WIDTH/WORD_SIZE. Beat transfer = data_ready && data_wanted in same cycle.
//  - FSM: IDLE -> (start) FETCH, or DONE if word_count==0; FETCH -> (transfer) UNPACK;
//    UNPACK -> FETCH when beat exhausted and words remain; UNPACK -> CHECK/DONE after last word;
//    DONE -> IDLE after 1 cycle, setting loaded=1.
//  - data_wanted = 1 only in FETCH (and CHECK when enabled). Beat latched on transfer.
//  - UNPACK: one word per cycle, registered: beat accepted at cycle t -> first we at t+1,
//    word k of beat at t+1+k. Throughput WPB words per WPB+1 cycles.
//  - waddr increments 0..word_count-1, no wrap; word_count = 2**ADDR_WIDTH ends at all-ones.
//  - Final beat partially used: unused upper words discarded, no write.
//  - we is one-hot on captured bank_sel; bank_sel >= NUM_BANKS: load runs, no we ever asserted.
//  - start while busy ignored; start and reset same cycle: reset wins.
//  - Reset mid-load: immediate return to IDLE, loaded=0, partial bank data stays (not cleared).
//  - data_ready while data_wanted=0: ignored, beat is not consumed.
// CONFIGURATION
//  CASCADE_LOADER_CHECKSUM_EN defined: after last word, FSM enters CHECK, accepts one extra beat;
//   data[WORD_SIZE-1:0] compared with mod-2**WORD_SIZE sum of all written words; mismatch sets
//   chk_err (held until next accepted start), then DONE. loaded asserts regardless.
//  Undefined: no CHECK state, no trailing beat, chk_err port absent.
// STRUCTURE
//  - Package pkg_cascade_loader: state enum (IDLE, FETCH, UNPACK, CHECK, DONE), default parameter
//    constants, bank-select width function.
//  - Sub-module beat_unpacker: holds one beat, word index counter, emits word + last_of_beat.
//  - Top holds FSM, address/remaining counters, bank decode, optional checksum accumulator.
// TESTING
//  - Defaults, start bank 2 count 5, beats A,B,C -> we=4'b0100, waddr 0..4, words A0,A1,B0,B1,C0;
//    C1 unused; loaded=1 one cycle after last write.
//  - count 0 -> no data_wanted, no we, loaded=1 within 2 cycles of start.
//  - data_ready toggled randomly + start pulsed mid-load -> write sequence identical, start ignored.
//  - count 1024 -> 512 beats, last waddr 10'h3FF, no wrap write to 0.
//  - reset asserted during 3rd word -> next cycle all outputs 0, IDLE; new load completes normally.
//  - CHECKSUM_EN: words 1,2,3 then trailer 6 -> chk_err=0; trailer 7 -> chk_err=1.

Source files
------------

// File: rtl/multi_bank_cascade_loader_pkg.sv
// Shared types and defaults for the multi-bank cascade loader.
// The optional checksum trailer is enabled by defining CASCADE_LOADER_CHECKSUM_EN.
package pkg_cascade_loader;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    UNPACK = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_IN_WIDTH   = 64;
  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_BANKS  = 4;

  // Width of a selector over n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multi_bank_cascade_loader_beat_unpacker.sv
// Holds one input beat and walks a word index across it, LSB word first.
// next_word is the word after the one currently indexed; last_of_beat flags the top word.
module beat_unpacker
  import pkg_cascade_loader::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 advance,
  input  logic [IN_WIDTH-1:0]  beat,
  output logic [WORD_SIZE-1:0] next_word,
  output logic                 last_of_beat
);

  localparam int WPB = IN_WIDTH / WORD_SIZE;
  localparam int IW  = sel_width(WPB);

  logic [IN_WIDTH-1:0] beat_r;
  logic [IW-1:0]       idx_r;

  function automatic logic [WORD_SIZE-1:0] pick_word(input logic [IN_WIDTH-1:0] b, input int k);
    logic [WORD_SIZE-1:0] w;
    w = {WORD_SIZE{1'b0}};
    for (int i = 0; i < WPB; i++) begin
      if (i == k) begin
        w = b[i*WORD_SIZE +: WORD_SIZE];
      end
    end
    return w;
  endfunction

  // Beat capture and word index stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_r <= {IN_WIDTH{1'b0}};
      idx_r  <= {IW{1'b0}};
    end else if (load) begin
      beat_r <= beat;
      idx_r  <= {IW{1'b0}};
    end else if (advance) begin
      idx_r  <= idx_r + IW'(1);
    end
  end

  // Word lookahead and end-of-beat decode.
  always_comb begin
    next_word    = pick_word(beat_r, int'(idx_r) + 1);
    last_of_beat = (int'(idx_r) == (WPB - 1));
  end

endmodule

// File: rtl/multi_bank_cascade_loader.sv
// Host-commanded loader: unpacks IN_WIDTH beats into WORD_SIZE words written to one of NUM_BANKS banks.
// Optional trailer checksum (CHECK state, chk_err port) when CASCADE_LOADER_CHECKSUM_EN is defined.
module multi_bank_cascade_loader
  import pkg_cascade_loader::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [sel_width(NUM_BANKS)-1:0]   bank_sel,
  input  logic [ADDR_WIDTH:0]               word_count,
  input  logic [IN_WIDTH-1:0]               data,
  input  logic                              data_ready,
  output logic                              data_wanted,
  output logic [NUM_BANKS-1:0]              we,
  output logic [ADDR_WIDTH-1:0]             waddr,
  output logic [WORD_SIZE-1:0]              wdata,
  output logic                              busy,
`ifdef CASCADE_LOADER_CHECKSUM_EN
  output logic                              chk_err,
`endif
  output logic                              loaded
);

  localparam int BSW = sel_width(NUM_BANKS);
  localparam int CW  = ADDR_WIDTH + 1;
`ifdef CASCADE_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t                state_r, next_state_s;
  logic [BSW-1:0]        bank_r;
  logic [CW-1:0]         rem_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [NUM_BANKS-1:0]  we_r;
  logic [ADDR_WIDTH-1:0] waddr_r;
  logic [WORD_SIZE-1:0]  wdata_r;
  logic                  busy_r, loaded_r, data_wanted_r;
  logic                  xfer_s, capture_s, load_beat_s, advance_s, emit_s, chk_s;
  logic [WORD_SIZE-1:0]  emit_word_s, next_word_s;
  logic                  last_of_beat_s;

  // Out-of-range bank selects decode to no enable at all.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BSW-1:0] b);
    logic [NUM_BANKS-1:0] oh;
    oh = {NUM_BANKS{1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (b == BSW'(i)) begin
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  assign xfer_s = data_ready && data_wanted_r;

  beat_unpacker #(
    .IN_WIDTH  (IN_WIDTH),
    .WORD_SIZE (WORD_SIZE)
  ) u_unpacker (
    .clk          (clk),
    .reset        (reset),
    .load         (load_beat_s),
    .advance      (advance_s),
    .beat         (data),
    .next_word    (next_word_s),
    .last_of_beat (last_of_beat_s)
  );

  // Next-state and word-emission decisions; an emitted word appears on the bus next cycle.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    load_beat_s  = 1'b0;
    advance_s    = 1'b0;
    emit_s       = 1'b0;
    emit_word_s  = {WORD_SIZE{1'b0}};
    chk_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s    = 1'b1;
          next_state_s = (word_count == {CW{1'b0}}) ? DONE : FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (xfer_s) begin
          load_beat_s  = 1'b1;
          emit_s       = 1'b1;
          emit_word_s  = data[WORD_SIZE-1:0];
          next_state_s = UNPACK;
        end else begin
          next_state_s = FETCH;
        end
      end
      UNPACK: begin
        // rem_r counts words still to emit after the one currently on the bus.
        if (rem_r == {CW{1'b0}}) begin
          next_state_s = END_STATE;
        end else if (last_of_beat_s) begin
          next_state_s = FETCH;
        end else begin
          advance_s    = 1'b1;
          emit_s       = 1'b1;
          emit_word_s  = next_word_s;
          next_state_s = UNPACK;
        end
      end
`ifdef CASCADE_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer_s) begin
          chk_s        = 1'b1;
          next_state_s = DONE;
        end else begin
          next_state_s = CHECK;
        end
      end
`endif
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      bank_r        <= {BSW{1'b0}};
      rem_r         <= {CW{1'b0}};
      addr_r        <= {ADDR_WIDTH{1'b0}};
      we_r          <= {NUM_BANKS{1'b0}};
      waddr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r       <= {WORD_SIZE{1'b0}};
      busy_r        <= 1'b0;
      loaded_r      <= 1'b0;
      data_wanted_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      busy_r        <= (next_state_s != IDLE);
      data_wanted_r <= (next_state_s == FETCH) || (next_state_s == CHECK);
      we_r          <= emit_s ? bank_onehot(bank_r) : {NUM_BANKS{1'b0}};
      if (emit_s) begin
        waddr_r <= addr_r;
        wdata_r <= emit_word_s;
      end
      if (capture_s) begin
        bank_r <= bank_sel;
        rem_r  <= word_count;
        addr_r <= {ADDR_WIDTH{1'b0}};
      end else if (emit_s) begin
        rem_r  <= rem_r - CW'(1);
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end
      if (next_state_s == DONE) begin
        loaded_r <= 1'b1;
      end else if (capture_s) begin
        loaded_r <= 1'b0;
      end
    end
  end

`ifdef CASCADE_LOADER_CHECKSUM_EN
  logic [WORD_SIZE-1:0] sum_r;
  logic                 chk_err_r;

  // Running mod-2**WORD_SIZE sum of written words and trailer comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r     <= {WORD_SIZE{1'b0}};
      chk_err_r <= 1'b0;
    end else if (capture_s) begin
      sum_r     <= {WORD_SIZE{1'b0}};
      chk_err_r <= 1'b0;
    end else if (emit_s) begin
      sum_r     <= sum_r + emit_word_s;
    end else if (chk_s) begin
      chk_err_r <= (data[WORD_SIZE-1:0] != sum_r);
    end
  end

  assign chk_err = chk_err_r;
`endif

  assign data_wanted = data_wanted_r;
  assign we          = we_r;
  assign waddr       = waddr_r;
  assign wdata       = wdata_r;
  assign busy        = busy_r;
  assign loaded      = loaded_r;

endmodule

// File: tb/tb_multi_bank_cascade_loader.sv
// Directed self-checking bench for multi_bank_cascade_loader at default parameters.
// Checksum scenarios are built only when CASCADE_LOADER_CHECKSUM_EN is defined.
module tb_multi_bank_cascade_loader;

  typedef struct packed {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  bank_sel;
  logic [10:0] word_count;
  logic [63:0] data;
  logic        data_ready;
  logic        data_wanted;
  logic [3:0]  we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        loaded;
`ifdef CASCADE_LOADER_CHECKSUM_EN
  logic        chk_err;
`endif

  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          cyc          = 0;
  int          last_we_cyc  = 0;
  int          loaded_rise_cyc = 0;
  int          dw_seen      = 0;
  int          beats_used   = 0;
  int          loop_cycles  = 0;
  logic        loaded_q     = 1'b0;
  wr_t         wr_q[$];
  logic [31:0] exp_q[$];
  logic [63:0] beats_q[$];

  multi_bank_cascade_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bank_sel    (bank_sel),
    .word_count  (word_count),
    .data        (data),
    .data_ready  (data_ready),
    .data_wanted (data_wanted),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .busy        (busy),
`ifdef CASCADE_LOADER_CHECKSUM_EN
    .chk_err     (chk_err),
`endif
    .loaded      (loaded)
  );

  always #5 clk = ~clk;

  // Observe the write bus and status a little after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (we != 4'b0000) begin
      wr_q.push_back({we, waddr, wdata});
      last_we_cyc = cyc;
    end
    if (data_wanted) dw_seen++;
    if (loaded && !loaded_q) loaded_rise_cyc = cyc;
    loaded_q = loaded;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compares the recorded write log against exp_q, all on bank enable exp_we.
  task automatic check_writes(input string tag, input logic [3:0] exp_we);
    int errs;
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= wr_q.size()) errs++;
      else if (wr_q[i].we !== exp_we || int'(wr_q[i].addr) != i || wr_q[i].data !== exp_q[i]) errs++;
    end
    check_val({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    check_val({tag, "_seq_errs"}, 64'(errs), 64'd0);
  endtask

  // Issues a load and feeds beats_q until the loader goes idle.
  task automatic run_load(input logic [1:0] bank, input logic [10:0] count,
                          input bit rnd, input bit pulse, input int reset_at);
    int n;
    int bi;
    wr_q.delete();
    dw_seen    = 0;
    bank_sel   = bank;
    word_count = count;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    bi = 0;
    while (busy && n < 6000) begin
      data       = (bi < beats_q.size()) ? beats_q[bi] : 64'h0;
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulse && n == 4) begin
        start      = 1'b1;
        bank_sel   = 2'd1;
        word_count = 11'd3;
      end else begin
        start = 1'b0;
      end
      if (reset_at >= 0 && we != 4'b0000 && int'(waddr) == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_we",          64'(we),          64'h0);
        check_val("rst_waddr",       64'(waddr),       64'h0);
        check_val("rst_wdata",       64'(wdata),       64'h0);
        check_val("rst_busy",        64'(busy),        64'h0);
        check_val("rst_loaded",      64'(loaded),      64'h0);
        check_val("rst_data_wanted", 64'(data_wanted), 64'h0);
        reset      = 1'b0;
        data_ready = 1'b0;
        return;
      end
      if (data_wanted && data_ready) bi++;
      @(negedge clk);
      n++;
    end
    start       = 1'b0;
    data_ready  = 1'b0;
    beats_used  = bi;
    loop_cycles = n;
    if (n >= 6000) check_val("load_timeout", 64'd1, 64'd0);
  endtask

  // Three beats A, B, C and the five words expected from them.
  task automatic setup_abc();
    beats_q = '{64'hAAAA0001_AAAA0000, 64'hBBBB0001_BBBB0000, 64'hCCCC0001_CCCC0000};
    exp_q   = '{32'hAAAA0000, 32'hAAAA0001, 32'hBBBB0000, 32'hBBBB0001, 32'hCCCC0000};
  endtask

  // Beats carrying words 0,1,2,... so word k is simply k.
  task automatic setup_ramp(input int nwords);
    beats_q.delete();
    exp_q.delete();
    for (int i = 0; i < (nwords + 1) / 2; i++) beats_q.push_back({32'(2 * i + 1), 32'(2 * i)});
    for (int k = 0; k < nwords; k++) exp_q.push_back(32'(k));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    bank_sel   = 2'd0;
    word_count = 11'd0;
    data       = 64'h0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    // Reset also wins over a simultaneous start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("reset_busy",        64'(busy),        64'h0);
    check_val("reset_loaded",      64'(loaded),      64'h0);
    check_val("reset_we",          64'(we),          64'h0);
    check_val("reset_waddr",       64'(waddr),       64'h0);
    check_val("reset_wdata",       64'(wdata),       64'h0);
    check_val("reset_data_wanted", 64'(data_wanted), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-length load.
    beats_q.delete();
    run_load(2'd1, 11'd0, 1'b0, 1'b0, -1);
    check_val("cnt0_writes",   64'(wr_q.size()), 64'd0);
    check_val("cnt0_dw_seen",  64'(dw_seen),     64'd0);
    check_val("cnt0_loaded",   64'(loaded),      64'd1);
    check_val("cnt0_within2",  64'(loop_cycles <= 2), 64'd1);

    // Bank 2, five words from three beats; C1 is discarded.
    setup_abc();
    run_load(2'd2, 11'd5, 1'b0, 1'b0, -1);
    check_writes("abc", 4'b0100);
    check_val("abc_beats",      64'(beats_used), 64'd3);
    check_val("abc_loaded",     64'(loaded),     64'd1);
    check_val("abc_loaded_lat", 64'(loaded_rise_cyc - last_we_cyc), 64'd1);

    // Same load with a stuttering data_ready and a start pulse mid-load.
    setup_abc();
    run_load(2'd2, 11'd5, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    check_writes("rnd", 4'b0100);
    check_val("rnd_idle_after",  64'(busy),       64'd0);
    check_val("rnd_loaded_lat",  64'(loaded_rise_cyc - last_we_cyc), 64'd1);

    // Bank 3, three words: second beat only half used.
    setup_ramp(3);
    run_load(2'd3, 11'd3, 1'b0, 1'b0, -1);
    check_writes("b3", 4'b1000);
    check_val("b3_beats", 64'(beats_used), 64'd2);

    // Full-depth load ends at the all-ones address without wrapping.
    setup_ramp(1024);
    run_load(2'd0, 11'd1024, 1'b0, 1'b0, -1);
    check_writes("full", 4'b0001);
    check_val("full_beats", 64'(beats_used), 64'd512);
    if (wr_q.size() > 0) check_val("full_last_waddr", 64'(wr_q[wr_q.size() - 1].addr), 64'h3FF);
    else check_val("full_last_waddr", 64'hFFFF, 64'h3FF);

    // Reset while the third word is on the bus, then a clean reload.
    setup_ramp(6);
    run_load(2'd1, 11'd6, 1'b0, 1'b0, 2);
    @(negedge clk);
    setup_abc();
    run_load(2'd2, 11'd5, 1'b0, 1'b0, -1);
    check_writes("after_rst", 4'b0100);
    check_val("after_rst_loaded", 64'(loaded), 64'd1);

`ifdef CASCADE_LOADER_CHECKSUM_EN
    // Words 1,2,3 sum to 6: trailer 6 passes, trailer 7 flags.
    beats_q = '{{32'd2, 32'd1}, {32'd0, 32'd3}, {32'd0, 32'd6}};
    exp_q   = '{32'd1, 32'd2, 32'd3};
    run_load(2'd0, 11'd3, 1'b0, 1'b0, -1);
    check_writes("cks_ok", 4'b0001);
    check_val("cks_ok_err",    64'(chk_err),    64'd0);
    check_val("cks_ok_loaded", 64'(loaded),     64'd1);
    check_val("cks_ok_beats",  64'(beats_used), 64'd3);
    beats_q = '{{32'd2, 32'd1}, {32'd0, 32'd3}, {32'd0, 32'd7}};
    run_load(2'd0, 11'd3, 1'b0, 1'b0, -1);
    check_val("cks_bad_err",    64'(chk_err), 64'd1);
    check_val("cks_bad_loaded", 64'(loaded),  64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
